// File: rtl/term_pkg.sv
// ---------------------------------------------------------------------------
// term_pkg
// Shared definitions for the terminal transmit path: UART FSM state encoding,
// the default bit period and the 8N1 frame shape.
// ---------------------------------------------------------------------------
package term_pkg;

    // Transmitter FSM states; encoding is fixed so debug taps read consistently.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 12 MHz / 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    // 8N1 frame: 8 data bits, no parity, 1 stop bit.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage : term_pkg

// File: rtl/term_uart_tx_if.sv
// ---------------------------------------------------------------------------
// term_uart_tx_if
// Byte-strobe input and status/serial output bundle of term_uart_tx.
//   i_data/i_data_v : byte strobe from the terminal buffer (no backpressure)
//   o_tx            : serial line, idle high
//   o_busy          : FSM active or FIFO non-empty
//   o_full          : FIFO at depth
//   o_overflow      : sticky, a write was dropped
//   o_level         : FIFO occupancy, FIFO_AW+1 bits
// master = byte producer, slave = transmitter.
// ---------------------------------------------------------------------------
interface term_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       i_data;
    logic             i_data_v;
    logic             o_tx;
    logic             o_busy;
    logic             o_full;
    logic             o_overflow;
    logic [FIFO_AW:0] o_level;

    modport master (
        output i_data, i_data_v,
        input  o_tx, o_busy, o_full, o_overflow, o_level
    );

    modport slave (
        input  i_data, i_data_v,
        output o_tx, o_busy, o_full, o_overflow, o_level
    );
endinterface : term_uart_tx_if

// File: rtl/term_fifo.sv
// ---------------------------------------------------------------------------
// term_fifo
// Synchronous byte FIFO, depth 2^FIFO_AW.
//   clk, rst : clock, synchronous active-high reset (flushes the FIFO)
//   push/din : write strobe and data; ignored when full
//   pop/dout : read strobe and head byte (dout is combinational from head)
//   level    : occupancy counter, FIFO_AW+1 bits
//   full     : level == depth
//   empty    : level == 0
// A push on a full FIFO is dropped even when a pop happens on the same edge.
// ---------------------------------------------------------------------------
module term_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic [FIFO_AW:0] level,
    output logic             full,
    output logic             empty
);
    localparam int                 DEPTH_N = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem_q [DEPTH_N];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Status flags come straight from the registered level.
    assign full  = (level_q == DEPTH);
    assign empty = (level_q == {(FIFO_AW+1){1'b0}});
    assign level = level_q;
    assign dout  = mem_q[rptr_q];

    // Next pointer/level; full/empty are judged on the pre-edge level.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        if (push_ok_s) begin
            wptr_d = wptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d = rptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{FIFO_AW{1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= {FIFO_AW{1'b0}};
            rptr_q  <= {FIFO_AW{1'b0}};
            level_q <= {(FIFO_AW+1){1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule : term_fifo

// File: rtl/term_uart_tx.sv
// ---------------------------------------------------------------------------
// term_uart_tx
// Buffers one-cycle byte strobes in term_fifo and sends each byte as an 8N1
// UART frame, LSB first.
//   clk, rst : clock, synchronous active-high reset (truncates frame, flushes)
//   bus      : term_uart_tx_if slave (i_data/i_data_v in; o_tx, o_busy,
//              o_full, o_overflow, o_level out)
// Parameters: CLKS_PER_BIT (>= 2) clocks per bit, FIFO_AW FIFO address width.
// Frames are spaced 10*CLKS_PER_BIT+1 cycles apart because IDLE always takes
// one cycle to pop the next byte.
// ---------------------------------------------------------------------------
module term_uart_tx
    import term_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    term_uart_tx_if.slave bus
);
    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_e          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ovf_q, ovf_d;
    logic               baud_last_s;
    logic               fifo_pop_s;
    logic [7:0]         fifo_dout_s;
    logic [FIFO_AW:0]   fifo_level_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    term_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.i_data_v),
        .din   (bus.i_data),
        .pop   (fifo_pop_s),
        .dout  (fifo_dout_s),
        .level (fifo_level_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign bus.o_tx       = tx_q;
    assign bus.o_busy     = (state_q != ST_IDLE) | ~fifo_empty_s;
    assign bus.o_full     = fifo_full_s;
    assign bus.o_overflow = ovf_q;
    assign bus.o_level    = fifo_level_s;

    // FSM next state, baud/bit counters, shifter and line value.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        fifo_pop_s  = 1'b0;
        baud_last_s = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_d    = fifo_dout_s;
                    baud_d     = {BAUD_W{1'b0}};
                    state_d    = ST_START;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + {{(BIT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line value follows the next state so o_tx is a clean register.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase

        // A write on a full FIFO (pre-edge) is dropped and latched as overflow.
        ovf_d = ovf_q | (bus.i_data_v & fifo_full_s);
    end

    // FSM, counters, shifter, line and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= {BAUD_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule : term_uart_tx

// File: tb/tb_term_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_term_uart_tx
// Directed bench for term_uart_tx with CLKS_PER_BIT=4, depth 16. A background
// receiver decodes frames from o_tx into a queue with their start cycle.
// ---------------------------------------------------------------------------
module tb_term_uart_tx;
    localparam int CPB = 4;
    localparam int AW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    logic [7:0]  rx_q [$];
    int unsigned rx_t [$];
    bit          rx_ok [$];

    always #5 clk = ~clk;

    // Free-running edge counter used to timestamp received frames.
    always @(posedge clk) cyc <= cyc + 1;

    term_uart_tx_if #(.FIFO_AW(AW)) bus ();

    term_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Background receiver: samples mid-bit on negedges.
    initial begin : rx_mon
        logic       prev;
        logic [7:0] b;
        bit         ok;
        int unsigned t;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && bus.o_tx === 1'b0) begin
                t  = cyc;
                ok = 1'b1;
                repeat (2) @(negedge clk);
                if (bus.o_tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.o_tx;
                end
                repeat (CPB) @(negedge clk);
                if (bus.o_tx !== 1'b1) ok = 1'b0;
                rx_q.push_back(b);
                rx_t.push_back(t);
                rx_ok.push_back(ok);
            end
            prev = bus.o_tx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.i_data   = b;
        bus.i_data_v = 1'b1;
        tick();
        bus.i_data_v = 1'b0;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_ok.delete();
    endtask

    // Reset, then let any truncated frame drain out of the receiver.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (45) tick();
        clear_rx();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.o_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.o_tx); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.o_full); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.o_overflow); end
        checks++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.o_level); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [9:0] frame;
        frame = {1'b1, 8'h41, 1'b0};
        do_reset();
        write_byte(8'h41);                        // edge 0
        checks++; if (bus.o_level !== 5'd1) begin errors++; $display("FAIL single_level0: got %0d want 1", bus.o_level); end
        checks++; if (bus.o_tx !== 1'b1) begin errors++; $display("FAIL single_tx0: got %b want 1", bus.o_tx); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy0: got %b want 1", bus.o_busy); end
        for (int k = 1; k <= 40; k++) begin
            tick();                               // edge k
            checks++;
            if (bus.o_tx !== frame[(k-1)/CPB]) begin
                errors++;
                $display("FAIL single_bit edge %0d: got %b want %b", k, bus.o_tx, frame[(k-1)/CPB]);
            end
            if (k == 1) begin
                checks++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL single_level1: got %0d want 0", bus.o_level); end
            end
        end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy40: got %b want 1", bus.o_busy); end
        tick();                                   // edge 41
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_busy41: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_tx !== 1'b1) begin errors++; $display("FAIL single_tx41: got %b want 1", bus.o_tx); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_byte(8'h55);
        write_byte(8'hAA);
        checks++; if (bus.o_level !== 5'd1) begin errors++; $display("FAIL b2b_level_a: got %0d want 1", bus.o_level); end
        repeat (20) tick();
        checks++; if (bus.o_level !== 5'd1) begin errors++; $display("FAIL b2b_level_b: got %0d want 1", bus.o_level); end
        wait_frames(2, 150);
        checks++;
        if (rx_q.size() !== 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", rx_q.size());
        end else begin
            checks++; if (rx_q[0] !== 8'h55) begin errors++; $display("FAIL b2b_byte0: got %h want 55", rx_q[0]); end
            checks++; if (rx_q[1] !== 8'hAA) begin errors++; $display("FAIL b2b_byte1: got %h want aa", rx_q[1]); end
            checks++; if (rx_t[1] - rx_t[0] !== 41) begin errors++; $display("FAIL b2b_spacing: got %0d want 41", rx_t[1] - rx_t[0]); end
            checks++; if (!(rx_ok[0] && rx_ok[1])) begin errors++; $display("FAIL b2b_framing: got %b%b want 11", rx_ok[0], rx_ok[1]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            write_byte(8'h10 + 8'(i));            // edge i
            if (i == 16) begin
                checks++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL ovf_full16: got %b want 1", bus.o_full); end
                checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag16: got %b want 0", bus.o_overflow); end
            end
            if (i == 17) begin
                checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag17: got %b want 1", bus.o_overflow); end
            end
        end
        wait_frames(17, 17 * 41 + 100);
        repeat (60) tick();
        checks++;
        if (rx_q.size() !== 17) begin
            errors++; $display("FAIL ovf_count: got %0d want 17", rx_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (rx_q[i] !== 8'h10 + 8'(i)) begin
                    errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'h10 + 8'(i));
                end
            end
        end
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [40];
        do_reset();
        for (int i = 0; i < 40; i++) begin
            exp[i] = 8'(i * 37 + 11);
            write_byte(exp[i]);
            wait_frames(i + 1, 100);
        end
        checks++;
        if (rx_q.size() !== 40) begin
            errors++; $display("FAIL wrap_count: got %0d want 40", rx_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (rx_q[i] !== exp[i] || !rx_ok[i]) begin
                    errors++; $display("FAIL wrap_byte%0d: got %h ok=%b want %h ok=1", i, rx_q[i], rx_ok[i], exp[i]);
                end
            end
        end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", bus.o_overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_byte(8'hA5);                        // edge 0, frame starts edge 1
        for (int i = 1; i < 6; i++) write_byte(8'h20 + 8'(i));
        checks++; if (bus.o_level !== 5'd5) begin errors++; $display("FAIL rmid_level_q: got %0d want 5", bus.o_level); end
        repeat (13) tick();                       // edge 18: DATA bit 3
        checks++; if (bus.o_tx !== 1'b0) begin errors++; $display("FAIL rmid_bit3: got %b want 0", bus.o_tx); end
        rst = 1'b1;
        tick();                                   // edge 19 samples rst
        checks++; if (bus.o_tx !== 1'b1) begin errors++; $display("FAIL rmid_tx: got %b want 1", bus.o_tx); end
        checks++; if (bus.o_level !== 5'd0) begin errors++; $display("FAIL rmid_level: got %0d want 0", bus.o_level); end
        rst = 1'b0;
        repeat (45) tick();
        clear_rx();
        write_byte(8'h3C);
        wait_frames(1, 100);
        repeat (5) tick();
        checks++;
        if (rx_q.size() !== 1) begin
            errors++; $display("FAIL rmid_count: got %0d want 1", rx_q.size());
        end else begin
            checks++; if (rx_q[0] !== 8'h3C || !rx_ok[0]) begin errors++; $display("FAIL rmid_byte: got %h ok=%b want 3c ok=1", rx_q[0], rx_ok[0]); end
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 17; i++) write_byte(8'h80 + 8'(i));   // edges 0..16
        repeat (25) tick();                                     // edge 41, FSM idle
        checks++; if (bus.o_level !== 5'd16) begin errors++; $display("FAIL fpp_level_pre: got %0d want 16", bus.o_level); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf_pre: got %b want 0", bus.o_overflow); end
        write_byte(8'hEE);                                      // edge 42, pop edge
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL fpp_ovf: got %b want 1", bus.o_overflow); end
        checks++; if (bus.o_level !== 5'd15) begin errors++; $display("FAIL fpp_level: got %0d want 15", bus.o_level); end
        checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL fpp_full: got %b want 0", bus.o_full); end
        checks++; if (bus.o_tx !== 1'b0) begin errors++; $display("FAIL fpp_start: got %b want 0", bus.o_tx); end
    endtask

    initial begin
        bus.i_data   = 8'h00;
        bus.i_data_v = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_mid();
        test_full_push_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_term_uart_tx

// File: doc/term_uart_tx.md
# term_uart_tx

Byte-to-serial transmitter for the terminal path. It accepts the one-cycle byte strobes produced by the terminal buffer (`i_data`/`i_data_v`, no backpressure) into a small synchronous FIFO, then serializes each byte as an 8N1 UART frame on `o_tx`. It sits between the terminal buffer's byte output and the board's TX pin, and absorbs bursts such as screen refreshes up to the FIFO depth.

## Interface
- `CLKS_PER_BIT`, default 104: clk cycles per UART bit (12 MHz / 115200); legal range ≥ 2.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW = 16.
- `clk` in, 1 bit: clock.
- `rst` in, 1 bit: reset, synchronous, active-high.
- `i_data` in, 8 bits: byte to transmit.
- `i_data_v` in, 1 bit: write strobe; `i_data` is sampled on every cycle this is high.
- `o_tx` out, 1 bit: serial line, idle high.
- `o_busy` out, 1 bit: high when the FSM is not IDLE or the FIFO is non-empty.
- `o_full` out, 1 bit: FIFO level == depth.
- `o_overflow` out, 1 bit: sticky; set when a write is dropped, cleared only by `rst`.
- `o_level` out, FIFO_AW+1 bits: current FIFO occupancy.

## Operation
- **Write:**
  - Accepted when `i_data_v` is high and the pre-edge level is below depth.
  - If the pre-edge level == depth, the byte is dropped and `o_overflow` is set. This holds even if a pop occurs on the same edge.
- **Simultaneous push and pop** on a non-full FIFO: both take effect and the level is unchanged.
- **Pointers:** FIFO_AW-bit read and write pointers wrap modulo depth. Level is a separate FIFO_AW+1-bit counter.
- **FSM states:** IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1; a bit index runs 0..7.
  - IDLE: `o_tx`=1. If the level is nonzero, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `o_tx` = shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7 completes, go to STOP; otherwise increment the bit index. Bits go out LSB first.
  - STOP: `o_tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Pacing:** IDLE always lasts at least 1 cycle, so back-to-back frames are 10·CLKS_PER_BIT+1 cycles apart.
- **Reset values:** `o_tx`=1, `o_busy`=0, `o_full`=0, `o_overflow`=0, `o_level`=0. State is IDLE and both pointers are 0.
- **Reset mid-frame:** the frame is truncated, `o_tx` is high from the next cycle, and the FIFO is flushed.

## Timing
- All outputs are registered or derived from registers; there are no combinational paths from inputs to outputs.
- **Write latency:** a write on edge N into an empty FIFO with the FSM idle gives `o_level`=1 after edge N. The pop happens on edge N+1, and `o_tx` goes 0 after edge N+1.
- **Frame length:** the start bit, 8 data bits and stop bit each last exactly CLKS_PER_BIT cycles.
- **Pop timing:** a pop occurs only in IDLE, on the edge that leaves IDLE, so at most once per frame.
- **Status updates:** `o_overflow` sets on the edge of the dropped write. `o_full` and `o_level` update on the same edge as the push or pop.

## Structure
- **Shared package `term_pkg`:**
  - FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3.
  - Default CLKS_PER_BIT.
  - Frame constants: 8 data bits, 1 stop bit.
- **Sub-module `term_fifo`:**
  - Parameter FIFO_AW.
  - Ports: push/din, pop/dout (dout shows the head combinationally), level, full, empty.
  - The FSM, baud counter and shifter live in `term_uart_tx`.

## Test plan
- **Single byte:** CLKS_PER_BIT=4; write 0x41 on edge 0.
  - `o_tx` goes low after edge 1.
  - Sequence is 0, then 1,0,0,0,0,0,1,0, then 1, each bit for 4 cycles.
  - Back in IDLE after edge 41; `o_busy`=0 after that.
- **Back-to-back:** write 0x55 and 0xAA on consecutive edges.
  - Second start bit begins exactly 41 cycles after the first.
  - `o_level` reads 1 while the first frame is sent.
- **Overflow:** write 20 distinct bytes on edges 0..19, depth 16.
  - Edges 17-19 are dropped and `o_overflow`=1 from edge 17.
  - Bytes 0..16 are transmitted in order; `o_full`=1 after edge 16.
- **Wrap-around:** 40 writes paced one per frame.
  - All 40 bytes come out in order and `o_overflow` stays 0.
  - Pointers wrap at least twice.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 5 bytes queued.
  - `o_tx`=1 the next cycle and `o_level`=0.
  - A new write after reset transmits a correct full frame.
- **Simultaneous push/pop when full:** FIFO full, write arrives on the pop edge.
  - Byte is dropped, `o_overflow`=1, and `o_level` becomes depth−1.
